// File: rtl/systolic_output_deskew_if.sv
// -----------------------------------------------------------------------------
// systolic_output_deskew_if
// Groups the capture, output-handshake and status signals of the systolic
// output deskew block.
//   master : the surrounding system (drives start/in_valid/in_psum/out_ready)
//   slave  : the deskew block (drives out_valid/out_row/out_idx/out_last and
//            the busy/done/overrun status)
// Lane/column j of in_psum and out_row sits at bits [j*W +: W].
// -----------------------------------------------------------------------------
interface systolic_output_deskew_if #(
   parameter int N = 10,
   parameter int W = 16
);
   logic           start;
   logic           in_valid;
   logic [N*W-1:0] in_psum;
   logic           out_valid;
   logic           out_ready;
   logic [N*W-1:0] out_row;
   logic [3:0]     out_idx;
   logic           out_last;
   logic           busy;
   logic           done;
   logic           overrun;

   modport master (
      output start, in_valid, in_psum, out_ready,
      input  out_valid, out_row, out_idx, out_last, busy, done, overrun
   );

   modport slave (
      input  start, in_valid, in_psum, out_ready,
      output out_valid, out_row, out_idx, out_last, busy, done, overrun
   );
endinterface

// File: rtl/systolic_output_deskew.sv
// -----------------------------------------------------------------------------
// systolic_output_deskew
// Captures the skewed bottom-row partial sums of an NxN systolic array and
// re-emits them as complete, time-aligned result rows through a valid/ready
// handshake.
//   clk  : sole clock, all state updates on posedge
//   rst  : synchronous, active-high reset
//   bus  : slave side of systolic_output_deskew_if
//          start      arms capture of one tile
//          in_valid   in_psum carries wavefront sample k
//          out_*      row output handshake (row, index, last flag)
//          busy       state is not IDLE
//          done       one-cycle pulse after the row N-1 handshake
//          overrun    sticky: sample arrived while draining
// At sample k lane j carries result[k-j][j] whenever 0 <= k-j <= N-1, so row r
// is complete once sample k = r+N-1 has been taken.
// -----------------------------------------------------------------------------
module systolic_output_deskew #(
   parameter int N = 10,
   parameter int W = 16
) (
   input  logic clk,
   input  logic rst,
   systolic_output_deskew_if.slave bus
);
   localparam int KW = $clog2(2 * N);
   localparam int IW = $clog2(N + 1);
   localparam logic [KW-1:0] LAST_K       = KW'(2 * N - 2);
   localparam logic [KW-1:0] FIRST_FULL_K = KW'(N - 1);
   localparam logic [IW-1:0] LAST_ROW     = IW'(N - 1);

   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

   state_t         state_reg;
   logic [KW-1:0]  k_reg;          // samples taken since arming
   logic [IW-1:0]  complete_reg;   // rows fully captured
   logic [IW-1:0]  emit_reg;       // rows loaded into the output register
   logic           out_valid_reg;
   logic [N*W-1:0] out_row_reg;
   logic [3:0]     out_idx_reg;
   logic           out_last_reg;
   logic           done_reg;
   logic           overrun_reg;

   logic           sample;
   logic           row_done_now;
   logic           avail;
   logic           take;
   logic [N*W-1:0] row_next;

   assign sample       = bus.in_valid && (state_reg == ARMED || state_reg == CAPTURE);
   // Lane N-1 supplies the last element of a row, so each sample from
   // k = N-1 onward completes exactly one row, in order.
   assign row_done_now = sample && (k_reg >= FIRST_FULL_K);
   assign avail        = (emit_reg < complete_reg) || row_done_now;
   assign take         = out_valid_reg && bus.out_ready;

   // One buffer per column: each lane writes at most one row per sample, so
   // every column memory sees a single write port.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_lane
         localparam logic [KW-1:0] J = KW'(gi);
         logic [W-1:0]  mem [N];
         logic [KW-1:0] rel;
         logic          wr_en;
         logic [IW-1:0] wr_row;

         assign rel    = k_reg - J;
         assign wr_en  = sample && (k_reg >= J) && (rel <= FIRST_FULL_K);
         assign wr_row = IW'(rel);

         always_ff @(posedge clk) begin
            if (wr_en) begin
               mem[wr_row] <= bus.in_psum[gi*W +: W];
            end
         end

         // Forward the incoming element when it lands in the row being
         // loaded this cycle; this lets a row leave one cycle after it
         // completes.
         assign row_next[gi*W +: W] = (wr_en && wr_row == emit_reg)
                                      ? bus.in_psum[gi*W +: W]
                                      : mem[emit_reg];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         k_reg         <= '0;
         complete_reg  <= '0;
         emit_reg      <= '0;
         out_valid_reg <= 1'b0;
         out_row_reg   <= '0;
         out_idx_reg   <= '0;
         out_last_reg  <= 1'b0;
         done_reg      <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  state_reg    <= ARMED;
                  k_reg        <= '0;
                  complete_reg <= '0;
                  emit_reg     <= '0;
               end
            end
            ARMED, CAPTURE: begin
               if (sample) begin
                  k_reg <= k_reg + 1'b1;
                  if (k_reg == LAST_K) begin
                     state_reg <= DRAIN;
                  end else begin
                     state_reg <= CAPTURE;
                  end
               end
            end
            DRAIN: begin
               if (bus.in_valid) begin
                  overrun_reg <= 1'b1;
               end
               if (take && out_last_reg) begin
                  state_reg <= IDLE;
                  done_reg  <= 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase

         if (row_done_now) begin
            complete_reg <= complete_reg + 1'b1;
         end

         // Output register refills when empty or when its row is accepted;
         // while stalled it holds row, index and last flag unchanged.
         if (!out_valid_reg || bus.out_ready) begin
            if (avail) begin
               out_valid_reg <= 1'b1;
               out_row_reg   <= row_next;
               out_idx_reg   <= 4'(emit_reg);
               out_last_reg  <= (emit_reg == LAST_ROW);
               emit_reg      <= emit_reg + 1'b1;
            end else begin
               out_valid_reg <= 1'b0;
            end
         end
      end
   end

   assign bus.out_valid = out_valid_reg;
   assign bus.out_row   = out_row_reg;
   assign bus.out_idx   = out_idx_reg;
   assign bus.out_last  = out_last_reg;
   assign bus.busy      = (state_reg != IDLE);
   assign bus.done      = done_reg;
   assign bus.overrun   = overrun_reg;
endmodule

// File: doc/systolic_output_deskew.md
SYSTOLIC_OUTPUT_DESKEW -- requirements
Module: systolic_output_deskew

Interface
REQ-001 The block SHALL have a parameter N, default 10, giving the array dimension (rows, columns, psum lanes).
REQ-002 The block SHALL have a parameter W, default 16, giving the signed psum width.
REQ-003 Port clk  input  1  sole clock; all state updates on posedge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port start  input  1  arms capture of one NxN result tile.
REQ-006 Port in_valid  input  1  bottom-row psum lanes carry a wavefront sample this cycle.
REQ-007 Port in_psum  input  N*W  signed bottom-row psums; lane j at bits [j*W +: W].
REQ-008 Port out_valid  output  1  out_row holds a complete result row.
REQ-009 Port out_ready  input  1  consumer accepts out_row.
REQ-010 Port out_row  output  N*W  deskewed result row; column j at bits [j*W +: W].
REQ-011 Port out_idx  output  4  row index of out_row, 0..N-1.
REQ-012 Port out_last  output  1  out_row is row N-1.
REQ-013 Port busy  output  1  high in any state other than IDLE.
REQ-014 Port done  output  1  one-cycle pulse after the final row handshake.
REQ-015 Port overrun  output  1  sticky error flag.

Function
REQ-016 States SHALL be IDLE, ARMED, CAPTURE, DRAIN.
- IDLE->ARMED: start=1.
- ARMED->CAPTURE: first in_valid=1; that sample is k=0.
- CAPTURE->DRAIN: on the edge sampling k=2N-2 (18).
- DRAIN->IDLE: on the handshake of row N-1.
REQ-017 k SHALL be the count of in_valid cycles since arming; it advances only on in_valid=1, so gaps stall capture without data loss.
REQ-018 At sample k, lane j SHALL be stored as result[k-j][j] only when 0 <= k-j <= N-1; other lanes are discarded.
REQ-019 Row r SHALL be complete after the edge sampling k=r+N-1; out_valid for row r SHALL rise on the next cycle at the earliest.
REQ-020 Rows SHALL be emitted strictly in order 0..N-1; one row transfers per cycle when out_valid and out_ready are both 1.
REQ-021 While out_valid=1 and out_ready=0, out_row, out_idx and out_last SHALL hold stable.
REQ-022 With out_ready held at 1 and in_valid continuous, rows SHALL emit on N consecutive cycles: row r one cycle after sample k=r+N-1.
REQ-023 Stored values SHALL pass bit-exact; no saturation, rounding or sign change.
REQ-024 done SHALL pulse for exactly one cycle, the cycle after the row N-1 handshake, in which the state is IDLE.
REQ-025 start outside IDLE SHALL be ignored, including during the final-handshake cycle.
REQ-026 in_valid in IDLE or ARMED-before-start SHALL be ignored with no flag.
REQ-027 in_valid in DRAIN SHALL drop the data and set overrun; overrun SHALL clear only on rst.
REQ-028 out_ready with out_valid=0 SHALL have no effect.

Reset
REQ-029 On rst=1 at a clock edge, the state SHALL become IDLE, k=0, and out_valid, out_idx, out_last, busy, done and overrun SHALL all be 0.
REQ-030 out_row SHALL be 0 after reset; buffer contents need no clearing.
REQ-031 rst mid-CAPTURE or mid-DRAIN SHALL abort the tile and drop any pending row; start in the reset cycle SHALL be ignored.

Verification
REQ-032 Nominal, N=10: start, then 19 consecutive in_valid with lane j at step k = 100*(k-j)+j inside the window, else -1; out_ready=1 -> rows 0..9 on 10 consecutive cycles, the first one cycle after k=9, row r col j = 100*r+j, done one cycle after row 9.
REQ-033 Backpressure: out_ready=0 until k=18 captured, then toggle 1/0 -> all 10 rows exact and in order, out_row stable while stalled, no overrun.
REQ-034 Gapped input: in_valid deasserted every other cycle -> same rows as REQ-032, timing shifted by the gaps.
REQ-035 Overrun: one extra in_valid during DRAIN -> overrun=1 and stays 1 through IDLE; output rows unchanged.
REQ-036 Reset abort: rst at k=12 -> next cycle out_valid=0, busy=0; a new start plus the REQ-032 stimulus reproduces correct results.
REQ-037 Signed extremes: lanes carrying -32768 and 32767 -> same values out, bit-exact.
